// File: rtl/iic_scl_seq.sv
// -----------------------------------------------------------------------------
// iic_scl_seq
//   Drives the I2C fan-out stage. It picks one of eight channels (iic_sel) and
//   produces a burst of SCL pulses at clk/(2*DIV). The framing keeps SCL high
//   whenever the channel select changes, so the fan-out never switches channel
//   while SCL is low:
//     IDLE -> SETTLE -> (LOW -> HIGH) x nbits -> HOLD -> IDLE
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (synchronous release expected)
//   start    in   request strobe, sampled only while busy=0
//   chan     in   [2:0] target channel, latched when start is accepted
//   nbits    in   [4:0] number of SCL pulses (0..31), latched with start
//   abort    in   cancel the current request, acted on only while busy=1
//   busy     out  request in progress
//   done     out  one-cycle pulse when a request completes normally
//   iic_sel  out  [7:0] channel select, 8'hFF = nothing selected
//   scl      out  master SCL, idle high
// -----------------------------------------------------------------------------
module iic_scl_seq #(
  parameter int DIV        = 250,
  parameter int SETTLE_CYC = 16,
  parameter int HOLD_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] chan,
  input  logic [4:0] nbits,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [7:0] iic_sel,
  output logic       scl
);

  // Half-period counter only ever counts 0..DIV-1.
  localparam int DW = $clog2(DIV);
  // The settle/hold counter covers 0..SETTLE_CYC and 0..HOLD_CYC-1.
  localparam int TMAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYC - 1);
  localparam logic [7:0]    SEL_NONE    = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LOW,
    S_HIGH,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [4:0]    pcnt_q, pcnt_d;
  logic [4:0]    nbits_q, nbits_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    sel_q, sel_d;
  logic          scl_q, scl_d;
  logic [4:0]    pcnt_inc;

  assign pcnt_inc = pcnt_q + 5'd1;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    tcnt_d  = tcnt_q;
    pcnt_d  = pcnt_q;
    nbits_d = nbits_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sel_d   = sel_q;
    scl_d   = scl_q;

    if (state_q != S_IDLE && abort) begin
      // Cancel: SCL rises in the same cycle the channel is released, so an
      // aborted low phase never leaves a selected channel with SCL low.
      state_d = S_IDLE;
      dcnt_d  = '0;
      tcnt_d  = '0;
      pcnt_d  = '0;
      nbits_d = '0;
      busy_d  = 1'b0;
      sel_d   = SEL_NONE;
      scl_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          scl_d = 1'b1;
          sel_d = SEL_NONE;
          if (start) begin
            state_d = S_SETTLE;
            nbits_d = nbits;
            sel_d   = {5'b0, chan};
            busy_d  = 1'b1;
            tcnt_d  = '0;
            dcnt_d  = '0;
            pcnt_d  = '0;
          end
        end

        S_SETTLE: begin
          if (tcnt_q == SETTLE_LAST) begin
            tcnt_d = '0;
            if (nbits_q != 5'd0) begin
              state_d = S_LOW;
              scl_d   = 1'b0;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end

        S_LOW: begin
          if (dcnt_q == DIV_LAST) begin
            dcnt_d  = '0;
            state_d = S_HIGH;
            scl_d   = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end

        S_HIGH: begin
          if (dcnt_q == DIV_LAST) begin
            dcnt_d = '0;
            pcnt_d = pcnt_inc;
            if (pcnt_inc == nbits_q) begin
              state_d = S_HOLD;
              tcnt_d  = '0;
            end else begin
              state_d = S_LOW;
              scl_d   = 1'b0;
            end
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end

        S_HOLD: begin
          if (tcnt_q == HOLD_LAST) begin
            state_d = S_IDLE;
            tcnt_d  = '0;
            pcnt_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sel_d   = SEL_NONE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          sel_d   = SEL_NONE;
          scl_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      tcnt_q  <= '0;
      pcnt_q  <= '0;
      nbits_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= SEL_NONE;
      scl_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      tcnt_q  <= tcnt_d;
      pcnt_q  <= pcnt_d;
      nbits_q <= nbits_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      scl_q   <= scl_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign iic_sel = sel_q;
  assign scl     = scl_q;

endmodule

// File: tb/tb_iic_scl_seq.sv
// -----------------------------------------------------------------------------
// tb_iic_scl_seq
//   Directed bench for iic_scl_seq with DIV=4, SETTLE_CYC=3, HOLD_CYC=3.
//   Edge 0 is the clock edge that samples an accepted start; outputs are
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_iic_scl_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] chan;
  logic [4:0] nbits;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] iic_sel;
  logic       scl;

  int vectors;
  int miscompares;

  // Channel-switch watcher state.
  logic [7:0] prev_sel;
  logic       prev_scl;
  logic       inv_en;

  iic_scl_seq #(
    .DIV        (4),
    .SETTLE_CYC (3),
    .HOLD_CYC   (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .chan    (chan),
    .nbits   (nbits),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .iic_sel (iic_sel),
    .scl     (scl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample just after it. Any change of iic_sel
  // must land with SCL high, and (outside abort/reset tests) SCL must also
  // have been high before the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (iic_sel !== prev_sel)
      chk("sel_chg_scl", {30'd0, (inv_en ? prev_scl : 1'b1), scl}, 32'd3);
    prev_sel = iic_sel;
    prev_scl = scl;
  endtask

  task automatic check_all(input string tag, input logic e_scl, input logic [7:0] e_sel,
                           input logic e_busy, input logic e_done);
    chk({tag, "_scl"},  {31'd0, scl},  {31'd0, e_scl});
    chk({tag, "_sel"},  {24'd0, iic_sel}, {24'd0, e_sel});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
  endtask

  initial begin
    int  rises;
    int  dones;
    int  k;
    bit  seen;

    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    chan   = 3'd0;
    nbits  = 5'd0;
    abort  = 1'b0;
    inv_en = 1'b1;
    prev_sel = 8'hFF;
    prev_scl = 1'b1;

    // ---- reset values ----
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("rst", 1'b1, 8'hFF, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    step();
    step();

    // ---- normal request chan=5 nbits=2 ----
    start = 1'b1; chan = 3'd5; nbits = 5'd2;
    for (int e = 0; e <= 24; e++) begin
      step();
      start = 1'b0;
      check_all($sformatf("norm_e%0d", e),
                !((e >= 4 && e <= 7) || (e >= 12 && e <= 15)),
                (e <= 22) ? 8'h05 : 8'hFF, (e <= 22), (e == 23));
    end

    // ---- zero pulses chan=0 nbits=0 ----
    start = 1'b1; chan = 3'd0; nbits = 5'd0;
    for (int e = 0; e <= 8; e++) begin
      step();
      start = 1'b0;
      check_all($sformatf("zero_e%0d", e), 1'b1,
                (e <= 6) ? 8'h00 : 8'hFF, (e <= 6), (e == 7));
    end

    // ---- ignored start at edge 6, abort sampled at edge 9 ----
    inv_en = 1'b0;
    start = 1'b1; chan = 3'd3; nbits = 5'd4;
    for (int e = 0; e <= 40; e++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      if (e == 5) begin start = 1'b1; chan = 3'd6; nbits = 5'd1; end
      if (e == 8) abort = 1'b1;
      if (e >= 6 && e <= 8)
        check_all($sformatf("ign_e%0d", e), !(e >= 4 && e <= 7), 8'h03, 1'b1, 1'b0);
      else if (e >= 9)
        check_all($sformatf("abt_e%0d", e), 1'b1, 8'hFF, 1'b0, 1'b0);
    end

    // ---- start+abort together in IDLE, then abort in mid LOW (edge 6) ----
    start = 1'b1; abort = 1'b1; chan = 3'd4; nbits = 5'd2;
    step();
    start = 1'b0; abort = 1'b0;
    check_all("sa_e0", 1'b1, 8'h04, 1'b1, 1'b0);
    for (int e = 1; e <= 5; e++) step();
    check_all("lowab_e5", 1'b0, 8'h04, 1'b1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_all("lowab_e6", 1'b1, 8'hFF, 1'b0, 1'b0);
    step();
    check_all("lowab_e7", 1'b1, 8'hFF, 1'b0, 1'b0);
    inv_en = 1'b1;

    // ---- back-to-back chan=1 then chan=7, nbits=1 each ----
    start = 1'b1; chan = 3'd1; nbits = 5'd1;
    dones = 0;
    seen  = 1'b0;
    k     = 0;
    while (k < 60 && dones < 2) begin
      step();
      k++;
      start = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) begin
          chk("b2b_done1_at", k - 1, 15);
          start = 1'b1; chan = 3'd7; nbits = 5'd1;
          step();
          k++;
          start = 1'b0;
          check_all("b2b_second", 1'b1, 8'h07, 1'b1, 1'b0);
        end
      end
    end
    chk("b2b_dones", dones, 2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b2b_quiet_done", {31'd0, done}, 32'd0);
    end

    // ---- reset mid-HIGH of chan=2 nbits=31 ----
    inv_en = 1'b0;
    start = 1'b1; chan = 3'd2; nbits = 5'd31;
    for (int e = 0; e <= 9; e++) begin
      step();
      start = 1'b0;
    end
    check_all("pre_rst", 1'b1, 8'h02, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b1, 8'hFF, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_all("post_rst", 1'b1, 8'hFF, 1'b0, 1'b0);
    inv_en = 1'b1;

    // ---- full nbits=31 run ----
    start = 1'b1; chan = 3'd2; nbits = 5'd31;
    rises = 0;
    k     = 0;
    seen  = 1'b0;
    while (k < 400 && !seen) begin
      logic last_scl;
      last_scl = scl;
      step();
      start = 1'b0;
      if (!last_scl && scl) rises++;
      if (done) seen = 1'b1;
      else k++;
    end
    chk("n31_done_seen", {31'd0, seen}, 32'd1);
    chk("n31_done_edge", k, 255);
    chk("n31_rises", rises, 31);
    check_all("n31_end", 1'b1, 8'hFF, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
